// File: rtl/vram_access_arbiter.sv
// Arbitrates the SDRAM VRAM controller between the VDP path (m0), a secondary engine (m1) and refresh.
// Optional grant counters are built when ARB_STATS_EN is defined; otherwise stat_* read as zero.
module vram_access_arbiter #(
  parameter int ADDR_W           = 17,
  parameter int REFRESH_INTERVAL = 1560,
  parameter int M1_MAX_WAIT      = 4,
  parameter int BUSY_TIMEOUT     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_size,
  input  logic [31:0]       m0_din,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_size,
  input  logic [31:0]       m1_din,
  output logic              m1_ack,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_size,
  output logic [31:0]       mem_din,
  input  logic              mem_busy,
  output logic [7:0]        err_cnt,
  output logic [15:0]       stat_m0,
  output logic [15:0]       stat_m1,
  output logic [15:0]       stat_ref,
  output logic [1:0]        fsm_state
);

  // Handshake: m*_req is a level held until the one-cycle m*_ack; the command fields are
  // captured on the IDLE edge that grants the port, so the requester may change them afterwards.

  localparam int RW = $clog2(REFRESH_INTERVAL + 1);
  localparam int SW = $clog2(M1_MAX_WAIT + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [RW-1:0] REF_MAX    = RW'(REFRESH_INTERVAL);
  localparam logic [RW-1:0] REF_HALF   = RW'(REFRESH_INTERVAL / 2);
  localparam logic [SW-1:0] STARVE_MAX = SW'(M1_MAX_WAIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {OWN_M0 = 2'd0, OWN_M1 = 2'd1, OWN_REF = 2'd2} owner_t;

  state_t state, state_nx;
  owner_t owner, sel;
  logic   grant;
  logic   wr_q;

  logic [RW-1:0] ref_cnt;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  logic refresh_due, refresh_opp, starve, timeout_hit, done, ack_fire;

  assign refresh_due = (ref_cnt >= REF_MAX);
  assign refresh_opp = (ref_cnt >= REF_HALF);
  assign starve      = m1_req && (starve_cnt >= STARVE_MAX);
  assign timeout_hit = (state == WAIT_BUSY) && !mem_busy && (to_cnt == TO_LAST);
  assign done        = (state == WAIT_DONE) && !mem_busy;
  assign ack_fire    = done || timeout_hit;

  // Source selection; only meaningful while the FSM idles with the controller free.
  always_comb begin
    grant = 1'b0;
    sel   = OWN_M0;
    if (state == IDLE && !mem_busy) begin
      if (refresh_due) begin
        grant = 1'b1;
        sel   = OWN_REF;
      end else if (starve) begin
        grant = 1'b1;
        sel   = OWN_M1;
      end else if (m0_req) begin
        grant = 1'b1;
        sel   = OWN_M0;
      end else if (m1_req) begin
        grant = 1'b1;
        sel   = OWN_M1;
      end else if (refresh_opp) begin
        grant = 1'b1;
        sel   = OWN_REF;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (grant) state_nx = ISSUE;
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: begin
        if (mem_busy) state_nx = WAIT_DONE;
        else if (timeout_hit) state_nx = IDLE;
      end
      WAIT_DONE: if (!mem_busy) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Command latch; a refresh keeps the previous address/data on the bus.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= OWN_M0;
      wr_q     <= 1'b0;
      mem_addr <= '0;
      mem_size <= '0;
      mem_din  <= '0;
    end else if (grant) begin
      owner <= sel;
      case (sel)
        OWN_M0: begin
          wr_q     <= m0_wr;
          mem_addr <= m0_addr;
          mem_size <= m0_size;
          mem_din  <= m0_din;
        end
        OWN_M1: begin
          wr_q     <= m1_wr;
          mem_addr <= m1_addr;
          mem_size <= m1_size;
          mem_din  <= m1_din;
        end
        default: wr_q <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_cnt    <= '0;
      starve_cnt <= '0;
      to_cnt     <= '0;
      err_cnt    <= '0;
    end else begin
      if (state == ISSUE && owner == OWN_REF) ref_cnt <= '0;
      else if (ref_cnt != REF_MAX)             ref_cnt <= ref_cnt + 1'b1;

      if (!m1_req || (grant && sel == OWN_M1))
        starve_cnt <= '0;
      else if (grant && sel == OWN_M0 && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;

      if (state == ISSUE)
        to_cnt <= '0;
      else if (state == WAIT_BUSY && !mem_busy && to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;

      if (timeout_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign mem_read    = (state == ISSUE) && (owner != OWN_REF) && !wr_q;
  assign mem_write   = (state == ISSUE) && (owner != OWN_REF) && wr_q;
  assign mem_refresh = (state == ISSUE) && (owner == OWN_REF);
  assign m0_ack      = ack_fire && (owner == OWN_M0);
  assign m1_ack      = ack_fire && (owner == OWN_M1);
  assign fsm_state   = state;

`ifdef ARB_STATS_EN
  logic [15:0] cnt_m0, cnt_m1, cnt_ref;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_m0  <= '0;
      cnt_m1  <= '0;
      cnt_ref <= '0;
    end else if (state == ISSUE) begin
      case (owner)
        OWN_M0:  cnt_m0  <= cnt_m0 + 16'd1;
        OWN_M1:  cnt_m1  <= cnt_m1 + 16'd1;
        default: cnt_ref <= cnt_ref + 16'd1;
      endcase
    end
  end

  assign stat_m0  = cnt_m0;
  assign stat_m1  = cnt_m1;
  assign stat_ref = cnt_ref;
`else
  assign stat_m0  = 16'h0;
  assign stat_m1  = 16'h0;
  assign stat_ref = 16'h0;
`endif

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Directed bench for vram_access_arbiter with a simple busy-responding controller model.
module tb_vram_access_arbiter;

  localparam logic [16:0] M0_ADDR = 17'h00A0A;
  localparam logic [16:0] M1_ADDR = 17'h1B0B0;

  logic        clk, rst;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [16:0] m0_addr, m1_addr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_din, m1_din;
  logic        m0_ack, m1_ack;
  logic        mem_read, mem_write, mem_refresh, mem_busy;
  logic [16:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_din;
  logic [7:0]  err_cnt;
  logic [15:0] stat_m0, stat_m1, stat_ref;
  logic [1:0]  fsm_state;

  int n_vec = 0;
  int n_fail = 0;
  int busy_len = 2;
  logic [1:0] grant_q[$];
  int m0_acks, m1_acks;

  // do_txn results
  int          s_cyc, a_cyc;
  logic [1:0]  s_kind;
  logic [16:0] s_addr;
  logic [31:0] s_din;
  logic [1:0]  s_size;

  vram_access_arbiter dut (
    .clk(clk), .reset(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_size(m0_size), .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_size(m1_size), .m1_din(m1_din), .m1_ack(m1_ack),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .mem_size(mem_size), .mem_din(mem_din), .mem_busy(mem_busy),
    .err_cnt(err_cnt), .stat_m0(stat_m0), .stat_m1(stat_m1), .stat_ref(stat_ref),
    .fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: busy rises just after the strobe edge and stays high for busy_len edges.
  initial begin
    mem_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ((mem_read || mem_write || mem_refresh) && busy_len > 0) begin
        mem_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 mem_busy = 1'b0;
      end
    end
  end

  // Grant log (0=m0, 1=m1, 2=refresh) and ack counters.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_refresh) grant_q.push_back(2'd2);
        else if (mem_read || mem_write) grant_q.push_back((mem_addr == M1_ADDR) ? 2'd1 : 2'd0);
        if (m0_ack) m0_acks++;
        if (m1_ack) m1_acks++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
    grant_q.delete();
    m0_acks = 0;
    m1_acks = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issues one transaction on a port and records strobe/ack cycles relative to the call.
  task automatic do_txn(input int port, input logic wr, input logic [16:0] addr,
                        input logic [1:0] size, input logic [31:0] din);
    s_cyc = 0; a_cyc = 0; s_kind = 2'b00; s_addr = '0; s_din = '0; s_size = '0;
    if (port == 0) begin
      m0_wr = wr; m0_addr = addr; m0_size = size; m0_din = din; m0_req = 1'b1;
    end else begin
      m1_wr = wr; m1_addr = addr; m1_size = size; m1_din = din; m1_req = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (s_cyc == 0 && (mem_read || mem_write)) begin
        s_cyc = c; s_kind = {mem_write, mem_read}; s_addr = mem_addr; s_din = mem_din; s_size = mem_size;
      end
      if ((port == 0 && m0_ack) || (port == 1 && m1_ack)) begin
        a_cyc = c;
        break;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  initial begin
    int first_ref, second_ref, ref_n, m0_before, ack_c, err_at_ack, acks_before;
    rst = 1'b1;
    m0_req = 0; m0_wr = 0; m0_addr = M0_ADDR; m0_size = 0; m0_din = 0;
    m1_req = 0; m1_wr = 0; m1_addr = M1_ADDR; m1_size = 0; m1_din = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_state", fsm_state, 2'd0);
    chk("rst_strobes", {mem_read, mem_write, mem_refresh}, 3'b000);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_addr", mem_addr, 17'h0);
    chk("rst_din", mem_din, 32'h0);
    chk("rst_err", err_cnt, 8'd0);
    chk("rst_stats", {stat_m0, stat_m1}, 32'h0);

    // Single m0 read, busy high for 4 cycles
    do_reset();
    busy_len = 4;
    do_txn(0, 1'b0, 17'h00123, 2'd1, 32'h0);
    chk("rd_strobe_cyc", s_cyc, 1);
    chk("rd_kind", s_kind, 2'b01);
    chk("rd_addr", s_addr, 17'h00123);
    chk("rd_size", s_size, 2'd1);
    chk("rd_ack_cyc", a_cyc, 5);
    @(negedge clk);
    chk("rd_ack_once", m0_acks, 1);
    chk("rd_no_m1_ack", m1_acks, 0);
    chk("rd_err", err_cnt, 8'd0);

    // Both ports held: four m0 grants then a forced m1 grant
    do_reset();
    busy_len = 2;
    m0_wr = 0; m0_addr = M0_ADDR; m1_wr = 0; m1_addr = M1_ADDR;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 200 && grant_q.size() < 10; c++) @(negedge clk);
    chk("fair_count", grant_q.size(), 10);
    chk("fair_g0", grant_q[0], 2'd0);
    chk("fair_g3", grant_q[3], 2'd0);
    chk("fair_g4", grant_q[4], 2'd1);
    chk("fair_g5", grant_q[5], 2'd0);
    chk("fair_g8", grant_q[8], 2'd0);
    chk("fair_g9", grant_q[9], 2'd1);
    chk("fair_m0_acks", m0_acks, 8);
    chk("fair_m1_acks", m1_acks, 1);
    m0_req = 1'b0; m1_req = 1'b0;

    // Idle: opportunistic refresh at half interval, counter restarts after each
    do_reset();
    busy_len = 2;
    first_ref = 0; second_ref = 0;
    for (int c = 1; c <= 1600; c++) begin
      @(negedge clk);
      if (mem_refresh) begin
        if (first_ref == 0) first_ref = c;
        else if (second_ref == 0) second_ref = c;
      end
    end
    chk("opp_ref_first", first_ref, 781);
    chk("opp_ref_second", second_ref, 1563);
    chk("opp_no_acks", m0_acks + m1_acks, 0);
    chk("opp_err", err_cnt, 8'd0);

    // m0 held for 2000 cycles: refresh forced ahead of pending m0
    do_reset();
    busy_len = 2;
    m0_wr = 0; m0_addr = M0_ADDR; m0_req = 1'b1;
    first_ref = 0; ref_n = 0; m0_before = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (mem_refresh) begin
        ref_n++;
        if (first_ref == 0) first_ref = c;
      end
      if (mem_read && first_ref == 0) m0_before++;
    end
    m0_req = 1'b0;
    chk("due_ref_cyc", first_ref, 1561);
    chk("due_m0_before", m0_before, 390);
    chk("due_ref_count", ref_n, 1);

    // Busy never rises: forced completion and saturating error count
    do_reset();
    busy_len = 0;
    m0_wr = 1; m0_addr = M0_ADDR; m0_din = 32'h1234_5678; m0_req = 1'b1;
    ack_c = 0; err_at_ack = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (m0_ack) begin
        ack_c = c;
        err_at_ack = int'(err_cnt);
        m0_req = 1'b0;
        break;
      end
    end
    chk("to_ack_cyc", ack_c, 4);
    chk("to_err_before", err_at_ack, 0);
    @(negedge clk);
    chk("to_err_after", err_cnt, 8'd1);
    chk("to_ack_low", m0_ack, 1'b0);
    m0_req = 1'b1;
    repeat (1700) @(negedge clk);
    m0_req = 1'b0;
    chk("to_err_sat", err_cnt, 8'hFF);

    // Reset asserted during WAIT_DONE
    do_reset();
    busy_len = 6;
    m0_wr = 0; m0_addr = M0_ADDR; m0_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_in_wait_done", fsm_state, 2'd3);
    rst = 1'b1;
    #1;
    chk("mid_state", fsm_state, 2'd0);
    chk("mid_outs", {mem_read, mem_write, mem_refresh, m0_ack, m1_ack}, 5'b0);
    chk("mid_addr", mem_addr, 17'h0);
    m0_req = 1'b0;
    acks_before = m0_acks;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_no_ack", m0_acks, acks_before);

    // Mixed traffic for grant counters and m1 write path
    do_reset();
    busy_len = 2;
    for (int i = 0; i < 3; i++) begin
      do_txn(0, 1'b0, M0_ADDR, 2'd0, 32'h0);
      chk("st_m0_ack", (a_cyc > 0), 1'b1);
    end
    do_txn(1, 1'b1, M1_ADDR, 2'd3, 32'hDEAD_BEEF);
    chk("st_wr_kind", s_kind, 2'b10);
    chk("st_wr_addr", s_addr, M1_ADDR);
    chk("st_wr_din", s_din, 32'hDEAD_BEEF);
    chk("st_wr_size", s_size, 2'd3);
    do_txn(1, 1'b0, M1_ADDR, 2'd2, 32'h0);
    chk("st_rd_kind", s_kind, 2'b01);
    @(negedge clk);
    chk("st_m0_acks", m0_acks, 3);
    chk("st_m1_acks", m1_acks, 2);
`ifdef ARB_STATS_EN
    chk("stat_m0", stat_m0, 16'd3);
    chk("stat_m1", stat_m1, 16'd2);
    chk("stat_ref", stat_ref, 16'd0);
`else
    chk("stat_m0", stat_m0, 16'd0);
    chk("stat_m1", stat_m1, 16'd0);
    chk("stat_ref", stat_ref, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
